// File: rtl/mem_stage_lsu_if.sv
// mem_stage_lsu_if: request/grant/response data bus between the memory stage
// and the memory system.
//   master (LSU)   : drives req, we, addr, wdata, be; receives gnt, rvalid, err, rdata
//   slave (memory) : the mirror image
// A request is held until gnt. A load then waits for rvalid. err qualifies
// the response, or the grant for stores.
interface mem_stage_lsu_if #(
    parameter int XLEN = 32
);
    logic              req;
    logic              we;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
    logic [XLEN/8-1:0] be;
    logic              gnt;
    logic              rvalid;
    logic              err;
    logic [XLEN-1:0]   rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  gnt, rvalid, err, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output gnt, rvalid, err, rdata
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory pipeline stage between execute and writeback, with a
// variable-latency bus.
//   clk, rst_n          : clock, asynchronous active-low reset
//   valid_in .. rd_addr_in : execute-stage slot (pc, address/result, store data, control)
//   stall, invalidate   : from the hazard unit
//   busy                : holds all earlier stages while an access is outstanding
//   bus                 : request/grant/response data bus (master side)
//   valid_out .. rd_addr_out, branch_taken_out : registered slot to writeback
// Non-memory or faulting slots pass through in one edge. Loads and stores are
// latched on accept and run through ACCESS (until grant), then RESP (loads,
// until rvalid). A completion seen under stall parks in DONE.
module mem_stage_lsu #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_in,
    input  logic            exception_in,
    input  logic [3:0]      ecause_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] alu_data_in,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            load,
    input  logic            store,
    input  logic            load_signed,
    input  logic            branch_taken_in,
    input  logic [1:0]      load_store_size,
    input  logic [4:0]      rd_addr_in,
    input  logic            stall,
    input  logic            invalidate,
    output logic            busy,
    output logic            branch_taken_out,
    mem_stage_lsu_if.master bus,
    output logic            valid_out,
    output logic            exception_out,
    output logic [3:0]      ecause_out,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] result_out,
    output logic [4:0]      rd_addr_out
);
    localparam int NB = XLEN / 8;
    localparam int LB = $clog2(NB);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP, DONE} state_t;

    typedef struct packed {
        logic            valid;
        logic            exc;
        logic [3:0]      cause;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] result;
        logic [4:0]      rd;
        logic            br;
    } wb_t;

    state_t          state, state_nx;
    wb_t             out_q, out_d, park_q, park_d, pass, done_val;
    logic            out_we, fin, fin_err;
    logic            to_execute, aligned, accept, br_fault, misalign, timed_out;
    logic [CW-1:0]   cnt;

    // request latched on accept; drives the bus unchanged until completion
    logic [XLEN-1:0] q_pc, q_addr, q_wdata;
    logic [NB-1:0]   q_be;
    logic [1:0]      q_size;
    logic [4:0]      q_rd;
    logic            q_load, q_signed, q_kill;

    logic [XLEN-1:0] st_wdata, shifted, ld_mask, ld_data;
    logic [NB-1:0]   st_be;
    logic [7:0]      be_base;
    logic            ld_sbit;

    assign to_execute = valid_in & ~exception_in & ~invalidate;
    assign br_fault   = branch_taken_in & (alu_data_in[1:0] != 2'b00);
    assign misalign   = (load | store) & ~aligned;
    assign accept     = (state == IDLE) & to_execute & (load | store) & aligned & ~stall;
    assign busy       = (state != IDLE) | accept;
    assign timed_out  = (TIMEOUT > 0) && (cnt == CW'(TIMEOUT - 1));

    always_comb begin
        case (load_store_size)
            2'd0:    aligned = 1'b1;
            2'd1:    aligned = ~alu_data_in[0];
            2'd2:    aligned = (alu_data_in[1:0] == 2'b00);
            default: aligned = (XLEN == 64) && (alu_data_in[2:0] == 3'b000);
        endcase
    end

    // store data is replicated across lanes; byte enables select the target bytes
    always_comb begin
        case (load_store_size)
            2'd0:    begin st_wdata = {NB{rs2_data[7:0]}};        be_base = 8'h01; end
            2'd1:    begin st_wdata = {(NB/2){rs2_data[15:0]}};   be_base = 8'h03; end
            2'd2:    begin st_wdata = {(XLEN/32){rs2_data[31:0]}}; be_base = 8'h0F; end
            default: begin st_wdata = rs2_data;                    be_base = 8'hFF; end
        endcase
        st_be = NB'({8'h00, be_base} << alu_data_in[LB-1:0]);
    end

    // load: bring the addressed lane down to bit 0, then extend
    assign shifted = bus.rdata >> {q_addr[LB-1:0], 3'b000};
    always_comb begin
        case (q_size)
            2'd0:    begin ld_mask = XLEN'(8'hFF);         ld_sbit = shifted[7];      end
            2'd1:    begin ld_mask = XLEN'(16'hFFFF);      ld_sbit = shifted[15];     end
            2'd2:    begin ld_mask = XLEN'(32'hFFFF_FFFF); ld_sbit = shifted[31];     end
            default: begin ld_mask = '1;                   ld_sbit = shifted[XLEN-1]; end
        endcase
        ld_data = (shifted & ld_mask) | ((q_signed & ld_sbit) ? ~ld_mask : '0);
    end

    // one-edge pass-through; upstream exception outranks local checks
    always_comb begin
        pass        = '0;
        pass.valid  = valid_in;
        pass.pc     = pc_in;
        pass.result = alu_data_in;
        pass.rd     = rd_addr_in;
        pass.cause  = ecause_in;
        pass.br     = to_execute & branch_taken_in & ~br_fault;
        if (valid_in & exception_in) begin
            pass.exc = 1'b1;
        end else if (to_execute & br_fault) begin
            pass.exc   = 1'b1;
            pass.cause = 4'd0;
        end else if (to_execute & misalign) begin
            pass.exc   = 1'b1;
            pass.cause = load ? 4'd4 : 4'd6;
        end
    end

    always_comb begin
        state_nx = state;
        out_we   = 1'b0;
        out_d    = '0;
        park_d   = park_q;
        fin      = 1'b0;
        fin_err  = 1'b0;
        done_val = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = ACCESS;
                    out_we   = 1'b1;          // bubble while the access runs
                end else if (invalidate) begin
                    out_we = 1'b1;
                end else if (!stall) begin
                    out_we = 1'b1;
                    out_d  = pass;
                end
            end
            ACCESS: begin
                // grant outranks invalidate and timeout in the same cycle
                if (bus.gnt) begin
                    if (q_load) begin
                        state_nx = RESP;
                    end else begin
                        fin     = 1'b1;
                        fin_err = bus.err;
                    end
                end else if (invalidate) begin
                    state_nx = IDLE;
                    out_we   = 1'b1;
                end else if (timed_out) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end
            end
            RESP: begin
                if (bus.rvalid) begin
                    fin     = 1'b1;
                    fin_err = bus.err;
                end else if (timed_out) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end
            end
            DONE: begin
                if (!stall) begin
                    state_nx = IDLE;
                    out_we   = 1'b1;
                    out_d    = invalidate ? '0 : park_q;
                end
            end
            default: state_nx = IDLE;
        endcase

        if (fin) begin
            if (!(q_kill | invalidate)) begin
                done_val.valid  = 1'b1;
                done_val.exc    = fin_err;
                done_val.cause  = q_load ? 4'd5 : 4'd7;
                done_val.pc     = q_pc;
                done_val.result = (q_load & ~fin_err) ? ld_data : q_addr;
                done_val.rd     = q_rd;
            end
            if (stall) begin
                state_nx = DONE;
                park_d   = done_val;
            end else begin
                state_nx = IDLE;
                out_we   = 1'b1;
                out_d    = done_val;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q    <= '0;
            park_q   <= '0;
            q_pc     <= '0;
            q_addr   <= '0;
            q_wdata  <= '0;
            q_be     <= '0;
            q_size   <= '0;
            q_rd     <= '0;
            q_load   <= 1'b0;
            q_signed <= 1'b0;
            q_kill   <= 1'b0;
            cnt      <= '0;
        end else begin
            if (out_we) out_q <= out_d;
            park_q <= park_d;
            if (accept) begin
                q_pc     <= pc_in;
                q_addr   <= alu_data_in;
                q_wdata  <= st_wdata;
                q_be     <= st_be;
                q_size   <= load_store_size;
                q_rd     <= rd_addr_in;
                q_load   <= load;
                q_signed <= load_signed;
                q_kill   <= 1'b0;
                cnt      <= '0;
            end else if (state == ACCESS || state == RESP) begin
                cnt <= cnt + 1'b1;
                // invalidate after grant: the bus transaction runs to completion, result dropped
                if (invalidate && (state == RESP || bus.gnt)) q_kill <= 1'b1;
            end
        end
    end

    assign bus.req          = (state == ACCESS);
    assign bus.we           = ~q_load;
    assign bus.addr         = q_addr;
    assign bus.wdata        = q_wdata;
    assign bus.be           = q_be;

    assign valid_out        = out_q.valid;
    assign exception_out    = out_q.exc;
    assign ecause_out       = out_q.cause;
    assign pc_out           = out_q.pc;
    assign result_out       = out_q.result;
    assign rd_addr_out      = out_q.rd;
    assign branch_taken_out = out_q.br;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu (XLEN=32, TIMEOUT=4).
module tb_mem_stage_lsu;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            valid_in, exception_in, load, store, load_signed, branch_taken_in;
    logic [3:0]      ecause_in;
    logic [XLEN-1:0] pc_in, alu_data_in, rs2_data;
    logic [1:0]      load_store_size;
    logic [4:0]      rd_addr_in;
    logic            stall, invalidate;
    logic            busy, branch_taken_out, valid_out, exception_out;
    logic [3:0]      ecause_out;
    logic [XLEN-1:0] pc_out, result_out;
    logic [4:0]      rd_addr_out;

    int n_cmp = 0;
    int n_bad = 0;

    mem_stage_lsu_if #(.XLEN(XLEN)) bus ();

    mem_stage_lsu #(.XLEN(XLEN), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .valid_in(valid_in), .exception_in(exception_in), .ecause_in(ecause_in),
        .pc_in(pc_in), .alu_data_in(alu_data_in), .rs2_data(rs2_data),
        .load(load), .store(store), .load_signed(load_signed),
        .branch_taken_in(branch_taken_in), .load_store_size(load_store_size),
        .rd_addr_in(rd_addr_in), .stall(stall), .invalidate(invalidate),
        .busy(busy), .branch_taken_out(branch_taken_out), .bus(bus),
        .valid_out(valid_out), .exception_out(exception_out), .ecause_out(ecause_out),
        .pc_out(pc_out), .result_out(result_out), .rd_addr_out(rd_addr_out)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr;
        valid_in = 0; exception_in = 0; ecause_in = 0; pc_in = 0; alu_data_in = 0;
        rs2_data = 0; load = 0; store = 0; load_signed = 0; branch_taken_in = 0;
        load_store_size = 0; rd_addr_in = 0; stall = 0; invalidate = 0;
        bus.gnt = 0; bus.rvalid = 0; bus.err = 0; bus.rdata = 0;
    endtask

    task automatic issue(input logic ld, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] rs2);
        valid_in = 1; load = ld; store = ~ld; load_store_size = sz; load_signed = sg;
        alu_data_in = addr; rs2_data = rs2; pc_in = 32'h200; rd_addr_in = 5'd7;
    endtask

    task automatic test_reset;
        clr();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %0h exp 0", valid_out); end
        n_cmp++; if (result_out !== 32'h0) begin n_bad++; $display("FAIL rst_result got %0h exp 0", result_out); end
        n_cmp++; if (bus.req !== 1'b0) begin n_bad++; $display("FAIL rst_req got %0h exp 0", bus.req); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %0h exp 0", busy); end
        rst_n = 1;
        tick();
    endtask

    task automatic test_passthrough;
        clr(); valid_in = 1; alu_data_in = 32'h55; pc_in = 32'h100; rd_addr_in = 5'd3;
        tick();
        n_cmp++; if (valid_out !== 1'b1) begin n_bad++; $display("FAIL pass_valid got %0h exp 1", valid_out); end
        n_cmp++; if (result_out !== 32'h55) begin n_bad++; $display("FAIL pass_result got %0h exp 55", result_out); end
        n_cmp++; if (pc_out !== 32'h100) begin n_bad++; $display("FAIL pass_pc got %0h exp 100", pc_out); end
        n_cmp++; if (rd_addr_out !== 5'd3) begin n_bad++; $display("FAIL pass_rd got %0h exp 3", rd_addr_out); end
        n_cmp++; if (exception_out !== 1'b0) begin n_bad++; $display("FAIL pass_exc got %0h exp 0", exception_out); end
        branch_taken_in = 1; alu_data_in = 32'h104;
        tick();
        n_cmp++; if (branch_taken_out !== 1'b1) begin n_bad++; $display("FAIL br_ok got %0h exp 1", branch_taken_out); end
        alu_data_in = 32'h102;
        tick();
        n_cmp++; if ({exception_out, ecause_out, branch_taken_out} !== {1'b1, 4'd0, 1'b0})
            begin n_bad++; $display("FAIL br_misal got exc=%0h cause=%0h br=%0h exp 1/0/0", exception_out, ecause_out, branch_taken_out); end
        branch_taken_in = 0; exception_in = 1; ecause_in = 4'd2; load = 1; load_store_size = 2; alu_data_in = 32'h3001;
        tick();
        n_cmp++; if ({exception_out, ecause_out, bus.req} !== {1'b1, 4'd2, 1'b0})
            begin n_bad++; $display("FAIL upstream_exc got exc=%0h cause=%0h req=%0h exp 1/2/0", exception_out, ecause_out, bus.req); end
        clr(); valid_in = 1; invalidate = 1; alu_data_in = 32'h77;
        tick();
        n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL idle_inval got %0h exp 0", valid_out); end
        clr();
        tick();
    endtask

    task automatic test_load_byte_signed;
        clr(); issue(1, 2'd0, 1, 32'h1003, 0);
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL lb_busy_accept got %0h exp 1", busy); end
        tick(); clr();
        n_cmp++; if ({bus.req, bus.we, bus.addr} !== {1'b1, 1'b0, 32'h1003})
            begin n_bad++; $display("FAIL lb_bus got req=%0h we=%0h addr=%0h exp 1/0/1003", bus.req, bus.we, bus.addr); end
        n_cmp++; if ({valid_out, busy} !== 2'b01) begin n_bad++; $display("FAIL lb_access got valid=%0h busy=%0h exp 0/1", valid_out, busy); end
        bus.gnt = 1;
        tick(); bus.gnt = 0;
        n_cmp++; if ({bus.req, busy} !== 2'b01) begin n_bad++; $display("FAIL lb_resp got req=%0h busy=%0h exp 0/1", bus.req, busy); end
        bus.rvalid = 1; bus.rdata = 32'h80123456;
        tick(); bus.rvalid = 0;
        n_cmp++; if (result_out !== 32'hFFFFFF80) begin n_bad++; $display("FAIL lb_result got %0h exp ffffff80", result_out); end
        n_cmp++; if ({valid_out, exception_out, busy} !== 3'b100)
            begin n_bad++; $display("FAIL lb_done got valid=%0h exc=%0h busy=%0h exp 1/0/0", valid_out, exception_out, busy); end
        n_cmp++; if ({pc_out, rd_addr_out} !== {32'h200, 5'd7}) begin n_bad++; $display("FAIL lb_pcrd got pc=%0h rd=%0h exp 200/7", pc_out, rd_addr_out); end
    endtask

    task automatic test_load_variants;
        logic [31:0] addr_t [4] = '{32'h1002, 32'h1001, 32'h1000, 32'h1002};
        logic [1:0]  size_t [4] = '{2'd1, 2'd0, 2'd2, 2'd1};
        logic        sgn_t  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] rd_t   [4] = '{32'h87654321, 32'h87654321, 32'hCAFEF00D, 32'h87654321};
        logic [31:0] exp_t  [4] = '{32'hFFFF8765, 32'h00000043, 32'hCAFEF00D, 32'h00008765};
        for (int i = 0; i < 4; i++) begin
            clr(); issue(1, size_t[i], sgn_t[i], addr_t[i], 0);
            tick(); clr(); bus.gnt = 1;
            tick(); bus.gnt = 0; bus.rvalid = 1; bus.rdata = rd_t[i];
            tick(); bus.rvalid = 0;
            n_cmp++; if ({valid_out, result_out} !== {1'b1, exp_t[i]})
                begin n_bad++; $display("FAIL ld_var%0d got valid=%0h res=%0h exp 1/%0h", i, valid_out, result_out, exp_t[i]); end
        end
    endtask

    task automatic test_store;
        clr(); issue(0, 2'd1, 0, 32'h2002, 32'h1234ABCD);
        tick(); clr();
        n_cmp++; if ({bus.req, bus.we, bus.be} !== {1'b1, 1'b1, 4'b1100})
            begin n_bad++; $display("FAIL sh_ctl got req=%0h we=%0h be=%0h exp 1/1/c", bus.req, bus.we, bus.be); end
        n_cmp++; if (bus.wdata !== 32'hABCDABCD) begin n_bad++; $display("FAIL sh_wdata got %0h exp abcdabcd", bus.wdata); end
        bus.gnt = 1;
        tick(); bus.gnt = 0;
        n_cmp++; if ({valid_out, exception_out, bus.req, busy} !== 4'b1000)
            begin n_bad++; $display("FAIL sh_done got valid=%0h exc=%0h req=%0h busy=%0h exp 1/0/0/0", valid_out, exception_out, bus.req, busy); end
        n_cmp++; if (result_out !== 32'h2002) begin n_bad++; $display("FAIL sh_result got %0h exp 2002", result_out); end
        clr(); issue(0, 2'd0, 0, 32'h2001, 32'h000000CD);
        tick(); clr();
        n_cmp++; if ({bus.be, bus.wdata} !== {4'b0010, 32'hCDCDCDCD})
            begin n_bad++; $display("FAIL sb_lane got be=%0h wdata=%0h exp 2/cdcdcdcd", bus.be, bus.wdata); end
        bus.gnt = 1; bus.err = 1;
        tick(); bus.gnt = 0; bus.err = 0;
        n_cmp++; if ({valid_out, exception_out, ecause_out} !== {1'b1, 1'b1, 4'd7})
            begin n_bad++; $display("FAIL st_err got valid=%0h exc=%0h cause=%0h exp 1/1/7", valid_out, exception_out, ecause_out); end
    endtask

    task automatic test_misaligned;
        clr(); issue(1, 2'd2, 0, 32'h3001, 0);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL misal_busy got %0h exp 0", busy); end
        tick();
        n_cmp++; if ({bus.req, valid_out, exception_out, ecause_out} !== {1'b0, 1'b1, 1'b1, 4'd4})
            begin n_bad++; $display("FAIL misal_ld got req=%0h valid=%0h exc=%0h cause=%0h exp 0/1/1/4", bus.req, valid_out, exception_out, ecause_out); end
        issue(0, 2'd1, 0, 32'h3003, 0);
        tick();
        n_cmp++; if ({bus.req, exception_out, ecause_out} !== {1'b0, 1'b1, 4'd6})
            begin n_bad++; $display("FAIL misal_st got req=%0h exc=%0h cause=%0h exp 0/1/6", bus.req, exception_out, ecause_out); end
        clr();
        tick();
    endtask

    task automatic test_timeout;
        clr(); issue(1, 2'd2, 0, 32'h4000, 0);
        tick(); clr();
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (bus.req !== 1'b1) begin n_bad++; $display("FAIL to_req%0d got %0h exp 1", i, bus.req); end
            tick();
        end
        n_cmp++; if ({bus.req, valid_out, exception_out, ecause_out} !== {1'b0, 1'b1, 1'b1, 4'd5})
            begin n_bad++; $display("FAIL to_fault got req=%0h valid=%0h exc=%0h cause=%0h exp 0/1/1/5", bus.req, valid_out, exception_out, ecause_out); end
    endtask

    task automatic test_stall_resp;
        clr(); issue(1, 2'd2, 0, 32'h5000, 0);
        tick(); clr(); bus.gnt = 1;
        tick(); bus.gnt = 0; bus.rvalid = 1; bus.rdata = 32'hDEADBEEF; stall = 1;
        tick(); bus.rvalid = 0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if ({valid_out, result_out, busy} !== {1'b0, 32'h0, 1'b1})
                begin n_bad++; $display("FAIL stall_hold%0d got valid=%0h res=%0h busy=%0h exp 0/0/1", i, valid_out, result_out, busy); end
            if (i < 2) tick();
        end
        tick(); stall = 0;
        tick();
        n_cmp++; if ({valid_out, result_out, busy} !== {1'b1, 32'hDEADBEEF, 1'b0})
            begin n_bad++; $display("FAIL stall_release got valid=%0h res=%0h busy=%0h exp 1/deadbeef/0", valid_out, result_out, busy); end
    endtask

    task automatic test_invalidate;
        clr(); issue(1, 2'd2, 0, 32'h6000, 0);
        tick(); clr(); invalidate = 1;
        tick(); invalidate = 0;
        n_cmp++; if ({bus.req, valid_out, busy} !== 3'b000)
            begin n_bad++; $display("FAIL inv_pre_gnt got req=%0h valid=%0h busy=%0h exp 0/0/0", bus.req, valid_out, busy); end
        issue(1, 2'd2, 0, 32'h6008, 0);
        tick(); clr(); bus.gnt = 1; invalidate = 1;
        tick(); bus.gnt = 0; invalidate = 0;
        n_cmp++; if ({bus.req, busy} !== 2'b01) begin n_bad++; $display("FAIL inv_gnt_resp got req=%0h busy=%0h exp 0/1", bus.req, busy); end
        bus.rvalid = 1; bus.rdata = 32'h12345678;
        tick(); bus.rvalid = 0;
        n_cmp++; if ({valid_out, result_out, busy} !== {1'b0, 32'h0, 1'b0})
            begin n_bad++; $display("FAIL inv_gnt_drop got valid=%0h res=%0h busy=%0h exp 0/0/0", valid_out, result_out, busy); end
    endtask

    task automatic test_reset_mid;
        clr(); issue(1, 2'd2, 0, 32'h7000, 0);
        tick(); clr();
        n_cmp++; if (bus.req !== 1'b1) begin n_bad++; $display("FAIL rm_req_pre got %0h exp 1", bus.req); end
        rst_n = 0;
        #1;
        n_cmp++; if ({bus.req, busy} !== 2'b00) begin n_bad++; $display("FAIL rm_access got req=%0h busy=%0h exp 0/0", bus.req, busy); end
        tick(); rst_n = 1;
        issue(1, 2'd2, 0, 32'h7004, 0);
        tick(); clr(); bus.gnt = 1;
        tick(); bus.gnt = 0;
        rst_n = 0;
        #1;
        n_cmp++; if ({bus.req, valid_out, busy} !== 3'b000)
            begin n_bad++; $display("FAIL rm_resp got req=%0h valid=%0h busy=%0h exp 0/0/0", bus.req, valid_out, busy); end
        tick(); rst_n = 1; bus.rvalid = 1; bus.rdata = 32'h11111111;
        tick(); bus.rvalid = 0;
        n_cmp++; if ({valid_out, result_out, busy} !== {1'b0, 32'h0, 1'b0})
            begin n_bad++; $display("FAIL rm_late_rvalid got valid=%0h res=%0h busy=%0h exp 0/0/0", valid_out, result_out, busy); end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_load_byte_signed();
        test_load_variants();
        test_store();
        test_misaligned();
        test_timeout();
        test_stall_resp();
        test_invalidate();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
